// File: rtl/mips_pkg.sv
// Shared widths for the MIPS pipeline: datapath, register addressing, write counter.
package mips_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned WRCNT_W    = 16;

    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [WRCNT_W-1:0]    wrcnt_t;

endpackage

// File: rtl/wb_mux.sv
// Write-back source select: load data when mem_r_en is set, otherwise the ALU result.
module wb_mux
    import mips_pkg::*;
(
    input  logic  mem_r_en,
    input  data_t alu_result,
    input  data_t mem_read_value,
    output data_t wb_value
);

    always_comb begin
        wb_value = mem_r_en ? mem_read_value : alu_result;
    end

endmodule

// File: rtl/wb_stage_regfile.sv
// Write-back stage plus 32x32 register file with a committed-write counter.
// Define WB_BYPASS_EN to make reads of the register being written return WB_value.
module wb_stage_regfile
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      WB_en,
    input  logic      MEM_R_EN,
    input  data_t     ALU_result,
    input  data_t     Mem_read_value,
    input  reg_addr_t Dest,
    input  reg_addr_t src1,
    input  reg_addr_t src2,
    output data_t     reg1,
    output data_t     reg2,
    output data_t     WB_value,
    output reg_addr_t WB_Dest,
    output logic      WB_WB_en,
    output wrcnt_t    wr_count
);

    data_t  regs [NUM_REGS];
    wrcnt_t wr_count_q;

    wb_mux u_wb_mux (
        .mem_r_en       (MEM_R_EN),
        .alu_result     (ALU_result),
        .mem_read_value (Mem_read_value),
        .wb_value       (WB_value)
    );

    // Qualifying on Dest != 0 keeps register 0 unwritten and uncounted.
    always_comb begin
        WB_Dest  = Dest;
        WB_WB_en = WB_en && (Dest != '0);
        wr_count = wr_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_count_q <= '0;
        end else if (WB_WB_en) begin
            regs[Dest] <= WB_value;
            wr_count_q <= wr_count_q + 1'b1;
        end
    end

    always_comb begin
        reg1 = (src1 == '0) ? '0 : regs[src1];
        reg2 = (src2 == '0) ? '0 : regs[src2];
`ifdef WB_BYPASS_EN
        // WB_WB_en already excludes Dest 0, so address 0 is never bypassed.
        if (WB_WB_en && (src1 == Dest)) reg1 = WB_value;
        if (WB_WB_en && (src2 == Dest)) reg2 = WB_value;
`endif
    end

endmodule
